// File: rtl/sdpram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sdpram_arb_pkg
// Shared constants and types for the two-requester simple-dual-port RAM
// arbiter.
//   NUM_REQ         : number of requesters per side (write and read)
//   DEF_ADDR_WIDTH  : default RAM address width
//   DEF_DATA_WIDTH  : default RAM data width
//   req_idx_t       : requester index (one bit for two requesters)
// -----------------------------------------------------------------------------
package sdpram_arb_pkg;

    localparam int NUM_REQ        = 2;
    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_DATA_WIDTH = 8;

    typedef logic req_idx_t;

endpackage : sdpram_arb_pkg

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with a one-bit priority pointer.
// The grant is purely combinational from req and the pointer. The pointer
// advances only on grants the parent actually accepted, so the parent can mask
// a raw grant (for example on an address collision) without disturbing
// fairness.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, clears the pointer to requester 0
//   req     : request per requester
//   accept  : grants accepted this cycle, after any masking by the parent
//   gnt     : raw one-hot (or zero) grant
// -----------------------------------------------------------------------------
module rr_arb2
    import sdpram_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] accept,
    output logic [NUM_REQ-1:0] gnt
);

    req_idx_t ptr_reg;
    req_idx_t ptr_next;

    always_comb begin
        gnt = '0;
        if (req == 2'b11) begin
            gnt = ptr_reg ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

    // Winner i hands priority to the other requester; idle cycles hold.
    always_comb begin
        ptr_next = ptr_reg;
        if (accept[0]) begin
            ptr_next = 1'b1;
        end else if (accept[1]) begin
            ptr_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule : rr_arb2

// File: rtl/sdpram_arbiter.sv
// -----------------------------------------------------------------------------
// sdpram_arbiter
// Arbitrates two write requesters and two read requesters onto the write and
// read ports of a simple dual-port RAM. Each side uses its own round-robin
// arbiter. Accepted accesses are registered onto the RAM ports one cycle
// later. Read data returns two cycles after the grant and is steered to the
// issuing requester by a two-stage index pipeline.
// Ports:
//   clk, rst                     : clock and synchronous active-high reset
//   wr_req/wr_addr/wr_data       : write requests per requester
//   wr_gnt                       : combinational one-hot write grant
//   rd_req/rd_addr               : read requests per requester
//   rd_gnt                       : combinational one-hot read grant
//   rd_valid/rd_data             : read return strobe (one-hot) and shared data
//   ram_wena/ram_addra/ram_dina  : RAM write port
//   ram_renb/ram_addrb           : RAM read port
//   ram_doutb                    : RAM read data, one cycle after renb
// -----------------------------------------------------------------------------
module sdpram_arbiter
    import sdpram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   wr_req,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   wr_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   wr_data,
    output logic [NUM_REQ-1:0]                   wr_gnt,
    input  logic [NUM_REQ-1:0]                   rd_req,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   rd_addr,
    output logic [NUM_REQ-1:0]                   rd_gnt,
    output logic [NUM_REQ-1:0]                   rd_valid,
    output logic [DATA_WIDTH-1:0]                rd_data,
    output logic                                 ram_wena,
    output logic [ADDR_WIDTH-1:0]                ram_addra,
    output logic [DATA_WIDTH-1:0]                ram_dina,
    output logic                                 ram_renb,
    output logic [ADDR_WIDTH-1:0]                ram_addrb,
    input  logic [DATA_WIDTH-1:0]                ram_doutb
);

    logic [NUM_REQ-1:0]    wr_gnt_raw;
    logic [NUM_REQ-1:0]    rd_gnt_raw;
    req_idx_t              wr_win;
    req_idx_t              rd_win;
    logic                  collision;

    logic                  ram_wena_reg;
    logic [ADDR_WIDTH-1:0] ram_addra_reg;
    logic [DATA_WIDTH-1:0] ram_dina_reg;
    logic                  ram_renb_reg;
    logic [ADDR_WIDTH-1:0] ram_addrb_reg;
    req_idx_t              idx1_reg;      // requester of the read on the RAM port
    logic                  rd_pend_reg;   // ram_doutb carries read data this cycle
    req_idx_t              idx2_reg;      // requester of that returning data
    logic [DATA_WIDTH-1:0] rd_hold_reg;

    rr_arb2 u_wr_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (wr_req),
        .accept (wr_gnt),
        .gnt    (wr_gnt_raw)
    );

    rr_arb2 u_rd_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (rd_req),
        .accept (rd_gnt),
        .gnt    (rd_gnt_raw)
    );

    assign wr_win = wr_gnt_raw[1];
    assign rd_win = rd_gnt_raw[1];

    // A read racing a write to the same address is deferred, so the read
    // lands on the RAM port after the write and returns the new data.
    assign collision = (|wr_gnt_raw) && (|rd_gnt_raw) &&
                       (rd_addr[rd_win] == wr_addr[wr_win]);

    assign wr_gnt = rst ? '0 : wr_gnt_raw;
    assign rd_gnt = (rst || collision) ? '0 : rd_gnt_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_wena_reg  <= 1'b0;
            ram_addra_reg <= '0;
            ram_dina_reg  <= '0;
            ram_renb_reg  <= 1'b0;
            ram_addrb_reg <= '0;
            idx1_reg      <= 1'b0;
            rd_pend_reg   <= 1'b0;
            idx2_reg      <= 1'b0;
            rd_hold_reg   <= '0;
        end else begin
            ram_wena_reg <= |wr_gnt;
            if (|wr_gnt) begin
                ram_addra_reg <= wr_addr[wr_win];
                ram_dina_reg  <= wr_data[wr_win];
            end
            ram_renb_reg <= |rd_gnt;
            if (|rd_gnt) begin
                ram_addrb_reg <= rd_addr[rd_win];
                idx1_reg      <= rd_win;
            end
            rd_pend_reg <= ram_renb_reg;
            idx2_reg    <= idx1_reg;
            if (rd_pend_reg) begin
                rd_hold_reg <= ram_doutb;
            end
        end
    end

    assign ram_wena  = ram_wena_reg;
    assign ram_addra = ram_addra_reg;
    assign ram_dina  = ram_dina_reg;
    assign ram_renb  = ram_renb_reg;
    assign ram_addrb = ram_addrb_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rd_valid
            assign rd_valid[gi] = rd_pend_reg && (int'(idx2_reg) == gi);
        end
    endgenerate

    // RAM data passes straight through when valid; otherwise the last
    // returned word is held.
    assign rd_data = rd_pend_reg ? ram_doutb : rd_hold_reg;

endmodule : sdpram_arbiter

// File: tb/tb_sdpram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdpram_arbiter
// Directed bench for sdpram_arbiter with a behavioural RAM attached to its
// RAM ports. Inputs change 1 ns after the rising edge. Outputs are checked
// 2 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_sdpram_arbiter;
    import sdpram_arb_pkg::*;

    localparam int AW = 6;
    localparam int DW = 8;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [1:0]                 wr_req;
    logic [1:0][AW-1:0]         wr_addr;
    logic [1:0][DW-1:0]         wr_data;
    logic [1:0]                 wr_gnt;
    logic [1:0]                 rd_req;
    logic [1:0][AW-1:0]         rd_addr;
    logic [1:0]                 rd_gnt;
    logic [1:0]                 rd_valid;
    logic [DW-1:0]              rd_data;
    logic                       ram_wena;
    logic [AW-1:0]              ram_addra;
    logic [DW-1:0]              ram_dina;
    logic                       ram_renb;
    logic [AW-1:0]              ram_addrb;
    logic [DW-1:0]              ram_doutb = '0;

    logic [DW-1:0] mem [64] = '{default: 8'h00};

    int checks_cnt = 0;
    int errors_cnt = 0;

    logic [7:0] tp_data [8] = '{8'h3A, 8'hC5, 8'h17, 8'hE2, 8'h6B, 8'h90, 8'h4D, 8'hF1};

    always #5 clk = ~clk;

    sdpram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_gnt    (wr_gnt),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .ram_wena  (ram_wena),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_renb  (ram_renb),
        .ram_addrb (ram_addrb),
        .ram_doutb (ram_doutb)
    );

    // Behavioural simple dual-port RAM, one cycle read latency.
    always @(posedge clk) begin
        if (ram_wena) mem[ram_addra] <= ram_dina;
        if (ram_renb) ram_doutb <= mem[ram_addrb];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_wr(input logic [1:0] req, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        wr_req     = req;
        wr_addr[0] = a0;
        wr_addr[1] = a1;
        wr_data[0] = d0;
        wr_data[1] = d1;
    endtask

    task automatic set_rd(input logic [1:0] req, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_req     = req;
        rd_addr[0] = a0;
        rd_addr[1] = a1;
    endtask

    initial begin
        // Reset with every request active.
        rst = 1'b1;
        set_wr(2'b11, 6'h05, 6'h06, 8'hAA, 8'h55);
        set_rd(2'b11, 6'h20, 6'h21);
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            check("rst wr_gnt", wr_gnt, 2'b00);
            check("rst rd_gnt", rd_gnt, 2'b00);
            check("rst ram_wena", ram_wena, 1'b0);
            check("rst ram_renb", ram_renb, 1'b0);
            check("rst ram_addra", ram_addra, 6'h00);
            check("rst ram_addrb", ram_addrb, 6'h00);
            check("rst ram_dina", ram_dina, 8'h00);
            check("rst rd_valid", rd_valid, 2'b00);
            check("rst rd_data", rd_data, 8'h00);
        end

        // C0: release, requester 0 wins on both sides.
        tick(); rst = 1'b0; settle();
        check("c0 wr_gnt", wr_gnt, 2'b01);
        check("c0 rd_gnt", rd_gnt, 2'b01);
        check("c0 ram_wena", ram_wena, 1'b0);

        // C1..C4: write fairness.
        tick(); set_rd(2'b00, 6'h20, 6'h21); settle();
        check("c1 wr_gnt", wr_gnt, 2'b10);
        check("c1 ram_wena", ram_wena, 1'b1);
        check("c1 ram_addra", ram_addra, 6'h05);
        check("c1 ram_dina", ram_dina, 8'hAA);
        check("c1 ram_renb", ram_renb, 1'b1);
        check("c1 ram_addrb", ram_addrb, 6'h20);

        tick(); settle();
        check("c2 wr_gnt", wr_gnt, 2'b01);
        check("c2 ram_addra", ram_addra, 6'h06);
        check("c2 ram_dina", ram_dina, 8'h55);
        check("c2 ram_renb", ram_renb, 1'b0);
        check("c2 rd_valid", rd_valid, 2'b01);
        check("c2 rd_data", rd_data, 8'h00);

        tick(); settle();
        check("c3 wr_gnt", wr_gnt, 2'b10);
        check("c3 ram_addra", ram_addra, 6'h05);
        check("c3 ram_dina", ram_dina, 8'hAA);
        check("c3 rd_valid", rd_valid, 2'b00);

        tick(); set_wr(2'b00, 6'h05, 6'h06, 8'hAA, 8'h55); settle();
        check("c4 wr_gnt", wr_gnt, 2'b00);
        check("c4 ram_wena", ram_wena, 1'b1);
        check("c4 ram_addra", ram_addra, 6'h06);
        check("c4 ram_dina", ram_dina, 8'h55);

        // C5..C9: read routing to alternating requesters.
        tick(); set_rd(2'b10, 6'h00, 6'h05); settle();
        check("c5 ram_wena", ram_wena, 1'b0);
        check("c5 rd_gnt", rd_gnt, 2'b10);

        tick(); set_rd(2'b01, 6'h06, 6'h05); settle();
        check("c6 rd_gnt", rd_gnt, 2'b01);

        tick(); set_rd(2'b00, 6'h06, 6'h05); settle();
        check("c7 rd_valid", rd_valid, 2'b10);
        check("c7 rd_data", rd_data, 8'hAA);

        tick(); settle();
        check("c8 rd_valid", rd_valid, 2'b01);
        check("c8 rd_data", rd_data, 8'h55);

        tick(); settle();
        check("c9 rd_valid", rd_valid, 2'b00);
        check("c9 rd_data hold", rd_data, 8'h55);

        // C10..C15: collision defers the read, and the read pointer holds.
        tick(); set_wr(2'b01, 6'h10, 6'h00, 8'h3C, 8'h00); set_rd(2'b10, 6'h00, 6'h10); settle();
        check("c10 wr_gnt", wr_gnt, 2'b01);
        check("c10 rd_gnt collide", rd_gnt, 2'b00);

        tick(); set_wr(2'b00, 6'h10, 6'h00, 8'h3C, 8'h00); set_rd(2'b11, 6'h30, 6'h10); settle();
        check("c11 rd_gnt", rd_gnt, 2'b10);
        check("c11 ram_wena", ram_wena, 1'b1);
        check("c11 ram_addra", ram_addra, 6'h10);
        check("c11 ram_dina", ram_dina, 8'h3C);

        tick(); set_rd(2'b01, 6'h30, 6'h10); settle();
        check("c12 rd_gnt", rd_gnt, 2'b01);
        check("c12 ram_renb", ram_renb, 1'b1);
        check("c12 ram_addrb", ram_addrb, 6'h10);

        tick(); set_rd(2'b00, 6'h30, 6'h10); settle();
        check("c13 rd_valid", rd_valid, 2'b10);
        check("c13 rd_data", rd_data, 8'h3C);

        tick(); settle();
        check("c14 rd_valid", rd_valid, 2'b01);
        check("c14 rd_data", rd_data, 8'h00);

        tick(); settle();
        check("c15 rd_valid", rd_valid, 2'b00);

        // C16..C20: reset the cycle after a read grant.
        tick(); set_rd(2'b01, 6'h05, 6'h00); settle();
        check("c16 rd_gnt", rd_gnt, 2'b01);

        tick(); rst = 1'b1;
        set_wr(2'b11, 6'h3E, 6'h3F, 8'h11, 8'h22); set_rd(2'b11, 6'h06, 6'h07); settle();
        check("c17 wr_gnt in rst", wr_gnt, 2'b00);
        check("c17 rd_gnt in rst", rd_gnt, 2'b00);
        check("c17 rd_valid", rd_valid, 2'b00);

        tick(); rst = 1'b0; settle();
        check("c18 wr_gnt ptr0", wr_gnt, 2'b01);
        check("c18 rd_gnt ptr0", rd_gnt, 2'b01);
        check("c18 rd_valid", rd_valid, 2'b00);
        check("c18 rd_data", rd_data, 8'h00);
        check("c18 ram_renb", ram_renb, 1'b0);
        check("c18 ram_wena", ram_wena, 1'b0);

        tick(); set_wr(2'b00, 6'h3E, 6'h3F, 8'h11, 8'h22); set_rd(2'b00, 6'h06, 6'h07); settle();
        check("c19 rd_valid", rd_valid, 2'b00);
        check("c19 ram_renb", ram_renb, 1'b1);
        check("c19 ram_addrb", ram_addrb, 6'h06);
        check("c19 ram_addra", ram_addra, 6'h3E);
        check("c19 ram_dina", ram_dina, 8'h11);

        tick(); settle();
        check("c20 rd_valid", rd_valid, 2'b01);
        check("c20 rd_data", rd_data, 8'h55);

        // Throughput: preload addresses 0..7, then stream reads with
        // concurrent writes to 8..15.
        for (int k = 0; k < 8; k++) begin
            tick(); set_wr(2'b10, 6'h00, AW'(k), 8'h00, tp_data[k]); settle();
            check("tp preload wr_gnt", wr_gnt, 2'b10);
        end
        for (int t = 0; t < 10; t++) begin
            tick();
            if (t < 8) begin
                set_rd(2'b01, AW'(t), 6'h00);
                set_wr(2'b10, 6'h00, AW'(8 + t), 8'h00, DW'(t));
            end else begin
                set_rd(2'b00, 6'h00, 6'h00);
                set_wr(2'b00, 6'h00, 6'h00, 8'h00, 8'h00);
            end
            settle();
            if (t < 8) begin
                check("tp rd_gnt", rd_gnt, 2'b01);
                check("tp wr_gnt", wr_gnt, 2'b10);
            end
            if (t >= 2) begin
                check("tp rd_valid", rd_valid, 2'b01);
                check("tp rd_data", rd_data, tp_data[t-2]);
            end
        end
        tick(); settle();
        check("tp end rd_valid", rd_valid, 2'b00);
        check("tp end rd_data hold", rd_data, tp_data[7]);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule : tb_sdpram_arbiter

// File: doc/sdpram_arbiter.md
SDPRAM_ARBITER -- requirements
Module: sdpram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 6, SHALL set the RAM address width.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the RAM data width.
REQ-003 clk  input  1  SHALL be the single clock; all logic updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 wr_req  input  2  SHALL carry one write request per requester (index 0, 1).
REQ-006 wr_addr  input  2 x ADDR_WIDTH  SHALL carry the write address per requester.
REQ-007 wr_data  input  2 x DATA_WIDTH  SHALL carry the write data per requester.
REQ-008 wr_gnt  output  2  SHALL be the one-hot write grant; a write is accepted at a rising edge where wr_req[i] and wr_gnt[i] are both high.
REQ-009 rd_req  input  2  SHALL carry one read request per requester.
REQ-010 rd_addr  input  2 x ADDR_WIDTH  SHALL carry the read address per requester.
REQ-011 rd_gnt  output  2  SHALL be the one-hot read grant, with the same acceptance rule as wr_gnt.
REQ-012 rd_valid  output  2  SHALL be the one-hot read-data-valid strobe, routed to the requester that issued the read.
REQ-013 rd_data  output  DATA_WIDTH  SHALL be the shared read data, qualified by rd_valid.
REQ-014 ram_wena, ram_addra, ram_dina  outputs  1/ADDR_WIDTH/DATA_WIDTH  SHALL drive the RAM write port.
REQ-015 ram_renb, ram_addrb  outputs  1/ADDR_WIDTH  SHALL drive the RAM read port.
REQ-016 ram_doutb  input  DATA_WIDTH  SHALL be the RAM read data, valid one cycle after the RAM samples renb.

Function
REQ-017 wr_gnt and rd_gnt SHALL be combinational from the current requests and the priority pointers.
- At most one bit of each grant is high.
- A grant is never high for a requester whose req is low.
REQ-018 Each side SHALL arbitrate round-robin with its own one-bit priority pointer.
- With both requesting, the pointed-to requester wins.
- After any accepted grant to requester i, the pointer SHALL move to 1-i.
- With no grant, the pointer SHALL hold.
REQ-019 A write accepted in cycle N SHALL appear on ram_wena/ram_addra/ram_dina in cycle N+1 (registered), with ram_wena low in cycles with no accepted write.
REQ-020 A read accepted in cycle N SHALL appear on ram_renb/ram_addrb in cycle N+1 (registered).
- rd_valid[i] SHALL be high in cycle N+2.
- rd_data SHALL equal ram_doutb in cycle N+2.
REQ-021 A two-stage requester-index pipeline SHALL route read data, so that back-to-back reads from alternating requesters return in issue order, one per cycle.
REQ-022 Collision rule: if the winning read address equals the winning write address in the same cycle, the arbiter SHALL hold rd_gnt low that cycle.
- The read pointer SHALL not move.
- The read SHALL be granted in a later cycle and return the newly written data.
REQ-023 Sustained throughput SHALL be one write and one read per cycle when there is no collision.
REQ-024 rd_data SHALL hold its last value when rd_valid is all-zero.

Reset
REQ-025 While rst is high, the following SHALL be 0 at the next rising edge: ram_wena, ram_renb, ram_addra, ram_addrb, ram_dina, rd_valid, rd_data, both pointers and the index pipeline.
REQ-026 While rst is high, wr_gnt and rd_gnt SHALL be forced to 0.
REQ-027 Reads in flight when rst asserts SHALL be discarded; no rd_valid SHALL be produced for them after reset.

Structure
REQ-028 Package sdpram_arb_pkg SHALL hold NUM_REQ=2, the default widths and the typedef req_idx_t (1 bit).
REQ-029 Sub-module rr_arb2 SHALL implement the 2-way round-robin grant and pointer, instantiated once for writes and once for reads; the collision mask is applied outside it.

Verification
REQ-030 Reset: assert rst 3 cycles with all requests high -> grants 0 and all outputs 0 throughout; after release, requester 0 wins first on both sides.
REQ-031 Fairness: hold wr_req=2'b11 with addresses 0x05/0x06 and data 0xAA/0x55 for 4 cycles -> wr_gnt 01,10,01,10, and ram_wena high from the next cycle with address/data alternating 05/AA, 06/55.
REQ-032 Read routing: after REQ-031, pulse rd_req[1] with addr 0x05 and, next cycle, rd_req[0] with addr 0x06 -> rd_valid 10 with data 0xAA, then 01 with data 0x55, two cycles after each grant.
REQ-033 Collision: in one cycle write addr 0x10 data 0x3C and read addr 0x10 -> rd_gnt 0 that cycle, granted next cycle, rd_data 0x3C.
REQ-034 Reset mid-read: assert rst the cycle after a read grant -> no rd_valid at any point; post-reset pointers are 0.
REQ-035 Throughput: a single requester holding rd_req for 8 cycles over addresses 0..7 -> 8 consecutive grants, and 8 consecutive rd_valid cycles returning the matching reference-model data.
